div_share_arbiter: RTL and testbench

//  Shares one sequential divider (GO/doneFlag handshake; quotient in X, remainder in R) among NREQ requesters.

---
 rtl/div_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 38 +++
 rtl/div_share_arbiter.sv | 162 ++++++++++++++++
 tb/tb_div_share_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// Shared encodings for the divider-sharing arbiter: FSM states and response error codes.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package div_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after i_ptr, wrapping NREQ-1 -> 0.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    // One extra bit so ptr+k can exceed NREQ-1 before the modulo fold.
    logic [IW:0] w_pos;
    logic        w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_pos >= (IW+1)'(NREQ)) begin
                w_pos = w_pos - (IW+1)'(NREQ);
            end
            if (!w_found && i_req[w_pos[IW-1:0]]) begin
                w_found              = 1'b1;
                o_gnt[w_pos[IW-1:0]] = 1'b1;
                o_idx                = w_pos[IW-1:0];
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one sequential divider among NREQ requesters with round-robin grant and a hang watchdog.
// Latency: grant 1 cycle after req; response 1 cycle after div_done (zero divisor: 1 cycle after req).
// Backpressure: one transaction in flight; other requesters hold req until granted.
module div_share_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] dividend,
    input  logic [NREQ*WIDTH-1:0] divisor,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]      resp_quot,
    output logic [WIDTH-1:0]      resp_rem,
    output logic [1:0]            resp_err,
    output logic                  div_go,
    output logic [WIDTH-1:0]      div_x,
    output logic [WIDTH-1:0]      div_y,
    input  logic                  div_done,
    input  logic [WIDTH-1:0]      div_q,
    input  logic [WIDTH-1:0]      div_r
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_idx;
    logic [NREQ-1:0]   r_gnt_oh;
    logic [WIDTH-1:0]  r_x;
    logic [WIDTH-1:0]  r_y;
    logic [WIDTH-1:0]  r_quot;
    logic [WIDTH-1:0]  r_rem;
    logic [1:0]        r_err;
    logic [CW-1:0]     r_cnt;

    logic [NREQ-1:0]   w_pick_oh;
    logic [IW-1:0]     w_pick_idx;
    logic              w_pick_any;
    logic [WIDTH-1:0]  w_dvd_arr [NREQ];
    logic [WIDTH-1:0]  w_dvs_arr [NREQ];
    logic [WIDTH-1:0]  w_dvd;
    logic [WIDTH-1:0]  w_dvs;
    logic              w_div0;
    logic              w_tmo;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_oh),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_dvd_arr[g] = dividend[g*WIDTH +: WIDTH];
        assign w_dvs_arr[g] = divisor[g*WIDTH +: WIDTH];
    end

    assign w_dvd  = w_dvd_arr[w_pick_idx];
    assign w_dvs  = w_dvs_arr[w_pick_idx];
    assign w_div0 = (w_dvs == '0);
    assign w_tmo  = (r_cnt == TMO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = w_div0 ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (div_done || w_tmo) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operands are captured once in IDLE; later req/operand changes cannot reach the divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_idx    <= '0;
            r_gnt_oh <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_err    <= ERR_OK;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_idx    <= w_pick_idx;
                        r_gnt_oh <= w_pick_oh;
                        r_x      <= w_dvd;
                        r_y      <= w_dvs;
                        if (w_div0) begin
                            r_quot <= '1;
                            r_rem  <= w_dvd;
                            r_err  <= ERR_DIV0;
                        end
                    end
                end
                ST_ISSUE: r_cnt <= '0;
                ST_WAIT: begin
                    // A done arriving on the last watchdog cycle still wins over the abort.
                    if (div_done) begin
                        r_quot <= div_q;
                        r_rem  <= div_r;
                        r_err  <= ERR_OK;
                    end else if (w_tmo) begin
                        r_quot <= '0;
                        r_rem  <= '0;
                        r_err  <= ERR_TMO;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_ptr <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign gnt        = (r_state != ST_IDLE) ? r_gnt_oh : '0;
    assign resp_valid = (r_state == ST_RESP) ? r_gnt_oh : '0;
    assign resp_quot  = r_quot;
    assign resp_rem   = r_rem;
    assign resp_err   = r_err;
    assign div_go     = (r_state == ST_ISSUE);
    assign div_x      = r_x;
    assign div_y      = r_y;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: directed table, round-robin/reset/operand corner sequences, random traffic.
// Expected behaviour comes from a transaction-timeline model (grant/response cycles computed per request).
module tb_div_share_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 64;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] dividend;
    logic [NREQ*WIDTH-1:0] divisor;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       resp_valid;
    logic [WIDTH-1:0]      resp_quot;
    logic [WIDTH-1:0]      resp_rem;
    logic [1:0]            resp_err;
    logic                  div_go;
    logic [WIDTH-1:0]      div_x;
    logic [WIDTH-1:0]      div_y;
    logic                  div_done;
    logic [WIDTH-1:0]      div_q;
    logic [WIDTH-1:0]      div_r;

    div_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .dividend(dividend), .divisor(divisor),
        .gnt(gnt), .resp_valid(resp_valid), .resp_quot(resp_quot), .resp_rem(resp_rem),
        .resp_err(resp_err), .div_go(div_go), .div_x(div_x), .div_y(div_y),
        .div_done(div_done), .div_q(div_q), .div_r(div_r)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // transaction model state
    int m_busy, m_w, m_g, m_r, m_x, m_y, m_q, m_rm, m_e, m_ptr, m_free, n_served;
    int next_lat, dv_lat, dv_cnt;
    int drop_on_resp, rand_on, stray_on;
    logic [NREQ-1:0] prev_gnt;
    logic [NREQ-1:0] grants[$];
    logic [NREQ-1:0] seen_rv;
    logic [WIDTH-1:0] seen_q, seen_r;
    logic [1:0]      seen_e;
    int              seen_cyc;

    typedef struct {
        int idx; int x; int y; int lat;
        int q;   int r; int e; int elat;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
        int j;
        for (int k = 0; k < NREQ; k++) begin
            j = (ptr + k) % NREQ;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_check();
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] ev;
        logic            eo;
        eg = '0; ev = '0; eo = 1'b0;
        if (m_busy != 0 && cyc >= m_g && cyc <= m_r) eg[m_w] = 1'b1;
        if (m_busy != 0 && cyc == m_g && m_y != 0)   eo = 1'b1;
        if (m_busy != 0 && cyc == m_r)               ev[m_w] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("div_go", 32'(div_go), 32'(eo));
        chk("resp_valid", 32'(resp_valid), 32'(ev));
        if (m_busy != 0 && cyc == m_r) begin
            chk("resp_quot", 32'(resp_quot), m_q);
            chk("resp_rem", 32'(resp_rem), m_rm);
            chk("resp_err", 32'(resp_err), m_e);
            m_busy = 0;
            m_ptr  = (m_w + 1) % NREQ;
            m_free = cyc + 1;
            n_served++;
            if (drop_on_resp != 0) req[m_w] = 1'b0;
        end
    endtask

    // Grant rule: an idle cycle with any request grants the next cycle; response timing from the divider.
    task automatic model_grant();
        if (m_busy == 0 && cyc >= m_free && req != '0) begin
            m_w    = pick(req, m_ptr);
            m_x    = int'(dividend[m_w*WIDTH +: WIDTH]);
            m_y    = int'(divisor[m_w*WIDTH +: WIDTH]);
            m_g    = cyc + 1;
            m_busy = 1;
            dv_lat = next_lat;
            if (m_y == 0) begin
                m_r = m_g; m_q = (1 << WIDTH) - 1; m_rm = m_x; m_e = 1;
            end else if (next_lat == 0) begin
                m_r = m_g + TIMEOUT + 1; m_q = 0; m_rm = 0; m_e = 2;
            end else begin
                m_r = m_g + next_lat + 1; m_q = m_x / m_y; m_rm = m_x % m_y; m_e = 0;
            end
        end
    endtask

    task automatic drive_random();
        for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && $urandom_range(3) == 0) begin
                req[i] = 1'b1;
                dividend[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                divisor[i*WIDTH +: WIDTH]  = ($urandom_range(7) == 0) ? '0 : WIDTH'($urandom);
            end
        end
        next_lat = ($urandom_range(24) == 0) ? 0 : int'($urandom_range(12, 1));
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (resp_valid != '0) begin
            seen_rv = resp_valid; seen_q = resp_quot; seen_r = resp_rem;
            seen_e = resp_err;    seen_cyc = cyc;
        end
        if (gnt != '0 && prev_gnt == '0) grants.push_back(gnt);
        prev_gnt = gnt;
        model_check();
        // divider: done L cycles after the go pulse it sees; latency 0 means it hangs
        div_done = 1'b0;
        if (dv_cnt > 0) begin
            dv_cnt--;
            if (dv_cnt == 0) begin
                div_done = 1'b1;
                div_q = (div_y != '0) ? div_x / div_y : '1;
                div_r = (div_y != '0) ? div_x % div_y : div_x;
            end
        end
        if (div_go && dv_lat > 0) dv_cnt = dv_lat;
        if (stray_on != 0 && m_busy == 0 && dv_cnt <= 0 && $urandom_range(5) == 0) begin
            div_done = 1'b1;
            div_q = WIDTH'($urandom);
            div_r = WIDTH'($urandom);
        end
        if (rand_on != 0) drive_random();
        model_grant();
    endtask

    task automatic apply_one(input int i, input int x, input int y);
        req[i] = 1'b1;
        dividend[i*WIDTH +: WIDTH] = WIDTH'(x);
        divisor[i*WIDTH +: WIDTH]  = WIDTH'(y);
    endtask

    task automatic run_served(input int target, input int bound, input string name);
        int n;
        n = 0;
        while (n_served < target && n < bound) begin
            tick();
            n++;
        end
        if (n_served < target) chk({name, " response wait"}, n_served, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int n;
        logic [NREQ-1:0] exp_oh;
        int rr_order[5] = '{0, 1, 2, 3, 0};

        tbl[0] = '{1, 13,  3,  3,  4,  1, 0,  5};
        tbl[1] = '{2,  9,  0,  5, 15,  9, 1,  1};
        tbl[2] = '{0, 15,  1,  1, 15,  0, 0,  3};
        tbl[3] = '{3,  7,  8,  7,  0,  7, 0,  9};
        tbl[4] = '{1,  0,  5,  2,  0,  0, 0,  4};
        tbl[5] = '{3, 14,  4,  0,  0,  0, 2, 66};
        tbl[6] = '{0,  8,  0,  3, 15,  8, 1,  1};
        tbl[7] = '{2, 12,  5, 63,  2,  2, 0, 65};
        tbl[8] = '{2, 12,  5, 64,  2,  2, 0, 66};

        rst_n = 1'b0; req = '0; dividend = '0; divisor = '0;
        div_done = 1'b0; div_q = '0; div_r = '0;
        m_busy = 0; m_ptr = 0; m_free = 0; n_served = 0; m_w = 0; m_g = 0; m_r = 0;
        m_x = 0; m_y = 0; m_q = 0; m_rm = 0; m_e = 0;
        next_lat = 2; dv_lat = 0; dv_cnt = -1;
        drop_on_resp = 1; rand_on = 0; stray_on = 0;
        prev_gnt = '0; seen_rv = '0; seen_q = '0; seen_r = '0; seen_e = '0; seen_cyc = -1;

        // reset state
        tick(); tick();
        chk("rst resp_quot", 32'(resp_quot), 0);
        chk("rst resp_rem", 32'(resp_rem), 0);
        chk("rst resp_err", 32'(resp_err), 0);
        chk("rst div_x", 32'(div_x), 0);
        chk("rst div_y", 32'(div_y), 0);
        rst_n = 1'b1;
        tick();

        // all four requesting continuously from rr_ptr 0
        drop_on_resp = 0; next_lat = 2; grants.delete();
        for (int i = 0; i < NREQ; i++) apply_one(i, 9 + i, i + 1);
        model_grant();
        n = 0;
        while (grants.size() < 5 && n < 300) begin tick(); n++; end
        req = '0;
        n = 0;
        while (m_busy != 0 && n < 100) begin tick(); n++; end
        tick();
        chk("rr grant count", grants.size(), 5);
        for (int k = 0; k < 5 && k < grants.size(); k++) begin
            exp_oh = '0; exp_oh[rr_order[k]] = 1'b1;
            chk($sformatf("rr grant %0d", k), 32'(grants[k]), 32'(exp_oh));
        end
        drop_on_resp = 1;

        // single-requester vectors
        for (int v = 0; v < 9; v++) begin
            next_lat = tbl[v].lat;
            seen_cyc = -1;
            apply_one(tbl[v].idx, tbl[v].x, tbl[v].y);
            model_grant();
            t0 = cyc;
            run_served(n_served + 1, 200, $sformatf("vec%0d", v));
            exp_oh = '0; exp_oh[tbl[v].idx] = 1'b1;
            chk($sformatf("vec%0d resp_valid", v), 32'(seen_rv), 32'(exp_oh));
            chk($sformatf("vec%0d quot", v), 32'(seen_q), tbl[v].q);
            chk($sformatf("vec%0d rem", v), 32'(seen_r), tbl[v].r);
            chk($sformatf("vec%0d err", v), 32'(seen_e), tbl[v].e);
            chk($sformatf("vec%0d latency", v), seen_cyc - t0, tbl[v].elat);
            tick();
        end

        // stray done while idle, then operands changed right after the grant
        div_done = 1'b1; div_q = 4'hA; div_r = 4'h5;
        tick(); tick();
        next_lat = 3;
        apply_one(0, 14, 4);
        model_grant();
        tick();
        dividend[0 +: WIDTH] = 4'd3;
        divisor[0 +: WIDTH]  = 4'd1;
        run_served(n_served + 1, 50, "latched operands");
        chk("latched resp_valid", 32'(seen_rv), 32'h1);
        chk("latched quot", 32'(seen_q), 3);
        chk("latched rem", 32'(seen_r), 2);
        tick();

        // reset while waiting on a hung divider
        next_lat = 0;
        apply_one(2, 11, 3);
        model_grant();
        for (int k = 0; k < 10; k++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst gnt", 32'(gnt), 0);
        chk("midrst resp_valid", 32'(resp_valid), 0);
        chk("midrst div_go", 32'(div_go), 0);
        chk("midrst resp_err", 32'(resp_err), 0);
        chk("midrst div_x", 32'(div_x), 0);
        m_busy = 0; m_ptr = 0; dv_cnt = -1; req = '0;
        tick(); tick();
        rst_n = 1'b1;
        m_free = cyc;
        tick();
        next_lat = 2; grants.delete();
        apply_one(0, 6, 2);
        apply_one(3, 7, 2);
        model_grant();
        run_served(n_served + 2, 60, "post-reset");
        chk("post-reset grants", grants.size(), 2);
        if (grants.size() >= 2) begin
            chk("post-reset first", 32'(grants[0]), 32'h1);
            chk("post-reset second", 32'(grants[1]), 32'h8);
        end

        // random traffic with stray done pulses
        rand_on = 1; stray_on = 1;
        for (int k = 0; k < 2500; k++) tick();
        rand_on = 0; stray_on = 0;
        n = 0;
        while ((req != '0 || m_busy != 0) && n < 3000) begin tick(); n++; end
        if (req != '0 || m_busy != 0) chk("random drain", 32'(req), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
